day10_channel_scanner: RTL and testbench

- Sequential channel scanner that drives the select/enable inputs of the 2x4 one-hot decoder stage (decoder en <- en_out, decoder a_in <- sel_out).
- Steps round-robin through the channels enabled in a 4-bit mask and holds each channel for a programmable dwell time.
- Supports start/stop control and reports its state through busy and step indications.

---
 rtl/day10_channel_scanner.sv | 114 +++++++++++
 tb/tb_day10_channel_scanner.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/day10_channel_scanner.sv
// day10_channel_scanner
//   Round-robin channel scanner that drives a 2x4 one-hot decoder stage
//   (decoder en <- en_out, decoder a_in <- sel_out). Each channel set in the
//   captured mask is presented for D = max(dwell_in,1) cycles. A stop request
//   lets the current dwell finish before the scanner returns to IDLE.
//
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous active-high reset
//   start_in  begin a scan (sampled in IDLE only)
//   stop_in   graceful stop request (sampled while busy)
//   dwell_in  cycles per channel, captured at start (0 treated as 1)
//   mask_in   channel enable mask, captured at start
//   sel_out   current channel index
//   en_out    channel enable
//   step_out  one-cycle pulse on every channel advance
//   busy_out  high while scanning
module day10_channel_scanner #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_in,
  input  logic               stop_in,
  input  logic [DWELL_W-1:0] dwell_in,
  input  logic [3:0]         mask_in,
  output logic [1:0]         sel_out,
  output logic               en_out,
  output logic               step_out,
  output logic               busy_out
);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t             state;
  logic [DWELL_W:0]   cnt;      // one bit wider than dwell so max dwell cannot wrap
  logic [DWELL_W:0]   dwell_q;
  logic [3:0]         mask_q;
  logic               stop_pend;
  logic [1:0]         first_sel;
  logic [1:0]         next_sel;

  // Lowest set bit of the incoming mask: first channel of a new scan.
  always_comb begin
    first_sel = 2'd0;
    for (int i = 3; i >= 0; i--)
      if (mask_in[i]) first_sel = 2'(i);
  end

  // Next set mask bit above sel_out, wrapping 3->0. Offset 4 wraps back to
  // the current channel, which covers the single-bit mask case. Scanning
  // offsets high-to-low lets the nearest set bit win.
  always_comb begin
    logic [1:0] idx;
    idx      = 2'd0;
    next_sel = sel_out;
    for (int k = 4; k >= 1; k--) begin
      idx = sel_out + 2'(k);
      if (mask_q[idx]) next_sel = idx;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      dwell_q   <= '0;
      mask_q    <= '0;
      stop_pend <= 1'b0;
      sel_out   <= 2'd0;
      en_out    <= 1'b0;
      step_out  <= 1'b0;
      busy_out  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          step_out <= 1'b0;
          if (start_in && (mask_in != 4'd0)) begin
            dwell_q   <= (dwell_in == '0) ? {{DWELL_W{1'b0}}, 1'b1} : {1'b0, dwell_in};
            mask_q    <= mask_in;
            sel_out   <= first_sel;
            cnt       <= {{DWELL_W{1'b0}}, 1'b1};
            stop_pend <= 1'b0;
            en_out    <= 1'b1;
            busy_out  <= 1'b1;
            state     <= SCAN;
          end
        end
        SCAN: begin
          if (cnt == dwell_q) begin
            if (stop_pend || stop_in) begin
              // Dwell complete with a stop outstanding: park on this channel.
              en_out    <= 1'b0;
              busy_out  <= 1'b0;
              step_out  <= 1'b0;
              stop_pend <= 1'b0;
              state     <= IDLE;
            end else begin
              sel_out  <= next_sel;
              cnt      <= {{DWELL_W{1'b0}}, 1'b1};
              step_out <= 1'b1;
            end
          end else begin
            cnt      <= cnt + 1'b1;
            step_out <= 1'b0;
            if (stop_in) stop_pend <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_day10_channel_scanner.sv
// Directed bench for day10_channel_scanner. Inputs change on the falling edge
// and outputs are sampled on the falling edge, i.e. half a cycle away from
// the active rising edge. Index i counts cycles after the start edge.
module tb_day10_channel_scanner;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_in = 1'b0;
  logic       stop_in = 1'b0;
  logic [7:0] dwell_in = 8'd0;
  logic [3:0] mask_in = 4'd0;
  logic [1:0] sel_out;
  logic       en_out, step_out, busy_out;

  int n_chk = 0;
  int n_err = 0;

  day10_channel_scanner #(.DWELL_W(8)) dut (
    .clk(clk), .rst(rst), .start_in(start_in), .stop_in(stop_in),
    .dwell_in(dwell_in), .mask_in(mask_in), .sel_out(sel_out),
    .en_out(en_out), .step_out(step_out), .busy_out(busy_out)
  );

  always #5 clk = ~clk;

  // Hand-written expected sequences.
  logic [1:0] fs_sel  [13] = '{0,0,0,1,1,1,2,2,2,3,3,3,0};
  logic       fs_step [13] = '{0,0,0,1,0,0,1,0,0,1,0,0,1};
  logic [1:0] sp_sel  [8]  = '{1,1,3,3,1,1,3,3};
  logic       sp_step [8]  = '{0,0,1,0,1,0,1,0};
  logic [1:0] d0_sel  [6]  = '{0,1,2,3,0,1};
  logic       d0_step [6]  = '{0,1,1,1,1,1};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (sel,en,busy,step packed)", tag, got, exp);
    end
  endtask

  task automatic expo(input string tag, input logic [1:0] s, input logic e,
                      input logic b, input logic st);
    chk(tag, {27'd0, sel_out, en_out, busy_out, step_out}, {27'd0, s, e, b, st});
  endtask

  // Start pulse on one edge; inputs scrambled afterwards to show they were captured.
  task automatic go(input logic [3:0] m, input logic [7:0] d);
    @(negedge clk); mask_in = m; dwell_in = d; start_in = 1'b1;
    @(negedge clk); start_in = 1'b0; mask_in = 4'h0; dwell_in = 8'd7;
  endtask

  task automatic do_rst();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  initial begin
    // Reset / idle
    #12 rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); expo("reset_idle", 2'd0, 1'b0, 1'b0, 1'b0);
    end

    // Start with empty mask is ignored
    go(4'h0, 8'd3);
    for (int i = 0; i < 3; i++) begin
      expo("mask0_ignored", 2'd0, 1'b0, 1'b0, 1'b0); @(negedge clk);
    end

    // Full scan, dwell 3; start_in held during scan must be ignored
    go(4'hF, 8'd3);
    for (int i = 0; i < 13; i++) begin
      expo("full_scan", fs_sel[i], 1'b1, 1'b1, fs_step[i]);
      start_in = (i == 4); mask_in = 4'h1;
      @(negedge clk);
    end
    start_in = 1'b0;
    do_rst();

    // Sparse mask with wrap
    go(4'b1010, 8'd2);
    for (int i = 0; i < 8; i++) begin
      expo("sparse_wrap", sp_sel[i], 1'b1, 1'b1, sp_step[i]); @(negedge clk);
    end
    do_rst();

    // Single-bit mask: channel 2 held, step every 3 cycles
    go(4'b0100, 8'd3);
    for (int i = 0; i < 9; i++) begin
      expo("single_bit", 2'd2, 1'b1, 1'b1, (i == 3 || i == 6)); @(negedge clk);
    end
    do_rst();

    // Graceful stop in second cycle of channel 1
    go(4'hF, 8'd4);
    for (int i = 0; i < 11; i++) begin
      if (i < 4)      expo("stop_ch0",  2'd0, 1'b1, 1'b1, 1'b0);
      else if (i < 8) expo("stop_ch1",  2'd1, 1'b1, 1'b1, (i == 4));
      else            expo("stop_idle", 2'd1, 1'b0, 1'b0, 1'b0);
      stop_in = (i == 5);
      @(negedge clk);
    end

    // Restart right away, stop on the dwell-end cycle
    go(4'hF, 8'd2);
    for (int i = 0; i < 6; i++) begin
      if (i < 2)      expo("stopend_ch0",  2'd0, 1'b1, 1'b1, 1'b0);
      else if (i < 4) expo("stopend_ch1",  2'd1, 1'b1, 1'b1, (i == 2));
      else            expo("stopend_idle", 2'd1, 1'b0, 1'b0, 1'b0);
      stop_in = (i == 3);
      @(negedge clk);
    end

    // dwell 0 and dwell 1 both advance every cycle; stop ends the scan at once
    go(4'hF, 8'd0);
    for (int i = 0; i < 6; i++) begin
      expo("dwell0", d0_sel[i], 1'b1, 1'b1, d0_step[i]); @(negedge clk);
    end
    stop_in = 1'b1; @(negedge clk); stop_in = 1'b0;
    expo("dwell0_stop", 2'd2, 1'b0, 1'b0, 1'b0);
    go(4'hF, 8'd1);
    for (int i = 0; i < 6; i++) begin
      expo("dwell1", d0_sel[i], 1'b1, 1'b1, d0_step[i]); @(negedge clk);
    end
    do_rst();

    // dwell 255: each channel held exactly 255 cycles
    go(4'b0011, 8'd255);
    for (int i = 0; i < 512; i++) begin
      if (i == 254 || i == 255 || i == 509 || i == 510 || i == 511)
        expo("dwell255", (i >= 255 && i < 510) ? 2'd1 : 2'd0, 1'b1, 1'b1,
             (i == 255 || i == 510));
      @(negedge clk);
    end
    do_rst();

    // Async reset mid-scan on channel 2, then restart from the lowest bit
    go(4'hF, 8'd4);
    for (int i = 0; i < 9; i++) @(negedge clk);
    expo("pre_async", 2'd2, 1'b1, 1'b1, 1'b0);
    #2 rst = 1'b1;
    #1 expo("async_rst", 2'd0, 1'b0, 1'b0, 1'b0);
    #1 rst = 1'b0;
    go(4'b1110, 8'd2);
    expo("after_rst0", 2'd1, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    @(negedge clk);
    expo("after_rst2", 2'd2, 1'b1, 1'b1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
